pc_fetch_seq: RTL and testbench

- Fetch-side program-counter sequencer for the WISC CPU.
- Owns the architectural PC and issues instruction-memory requests.
- Advances the PC by 2 per fetched instruction.
- Accepts branch/jump redirects carrying the target computed by the PC adder, and holds one fetched instruction for decode under a stall handshake.

---
 rtl/pc_fetch_seq_if.sv | 38 +++
 rtl/pc_fetch_seq.sv | 133 +++++++++++++
 tb/tb_pc_fetch_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq_if
// Bundles the fetch sequencer's control, instruction-memory and decode-side
// signals so they travel as one port.
//
//   master modport (fetch sequencer side):
//     in : stall, redirect_valid, redirect_target, imem_ready, imem_rdata
//     out: imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus2,
//          halted, misalign_fault
//   slave modport (memory / decode / branch unit side): mirror image.
// ---------------------------------------------------------------------------
interface pc_fetch_seq_if;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        misalign_fault;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_ready, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus2,
               halted, misalign_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_ready, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus2,
               halted, misalign_fault
    );
endinterface

// File: rtl/pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq
// Fetch-side program-counter sequencer for the WISC CPU. Owns the PC, issues
// instruction-memory requests (one per cycle with a zero-wait memory), holds
// one fetched instruction for decode under a stall handshake, accepts
// branch/jump redirects and stops fetching after a halt instruction has been
// consumed by decode.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : pc_fetch_seq_if.master (stall/redirect in, imem request/return,
//            held instruction out, halted, misalign_fault)
//
// Build option:
//   PC_ALIGN_CHECK_EN : when defined, a redirect to an odd target raises a
//   sticky misalign_fault and halts fetch instead of loading the PC. When
//   undefined the target LSB is dropped and misalign_fault is tied 0.
// ---------------------------------------------------------------------------
module pc_fetch_seq #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_seq_if.master bus
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;

    logic        w_run;
    logic        w_consume;
    logic        w_halt_consume;
    logic        w_req;
    logic        w_fetch;
    logic        w_bad_target;
    logic [15:0] w_redirect_pc;

    assign w_run          = (r_state == ST_RUN);
    assign w_consume      = r_instr_valid && !bus.stall;
    assign w_halt_consume = w_consume && (r_instr[15:12] == HALT_OPCODE);

    // No request while in reset, while halted, during a redirect cycle, or
    // while the held instruction is stalled in place.
    assign w_req   = rst_n && w_run && !bus.redirect_valid
                     && (!r_instr_valid || !bus.stall);
    assign w_fetch = w_req && bus.imem_ready;

    assign w_redirect_pc = {bus.redirect_target[15:1], 1'b0};

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_bad_target       = bus.redirect_target[0];
    assign bus.misalign_fault = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_run && bus.redirect_valid && w_bad_target) begin
            r_misalign <= 1'b1;
        end
    end
`else
    logic w_unused_tgt_lsb;

    assign w_unused_tgt_lsb   = bus.redirect_target[0];
    assign w_bad_target       = 1'b0;
    assign bus.misalign_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.redirect_valid) begin
                        // Redirect beats everything, including a same-cycle
                        // consume of a halt instruction.
                        r_instr_valid <= 1'b0;
                        if (w_bad_target) begin
                            r_state <= ST_HALTED;
                        end else begin
                            r_pc <= w_redirect_pc;
                        end
                    end else if (w_halt_consume) begin
                        // The request issued alongside the halt consume is
                        // squashed: data dropped, pc left where it is.
                        r_state       <= ST_HALTED;
                        r_instr_valid <= 1'b0;
                    end else if (w_fetch) begin
                        r_instr       <= bus.imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_pc          <= r_pc + 16'd2;
                    end else if (w_consume) begin
                        r_instr_valid <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    // Frozen until reset.
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.pc_plus2    = r_instr_pc + 16'd2;
    assign bus.halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_seq
// Self-checking bench for pc_fetch_seq: directed scenarios plus a randomized
// run compared against a transaction-level model of the fetch rules.
// ---------------------------------------------------------------------------
module tb_pc_fetch_seq;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk;
    logic rst_n;
    pc_fetch_seq_if bus ();

    pc_fetch_seq #(
        .RESET_PC    (RESET_PC),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic        m_halted;
    logic        m_mis;
    int          m_accepted;

    logic [15:0] halt_at = 16'hFFFF;

    // Memory contents: a function of the address, never with opcode F except
    // at the address chosen to hold a halt.
    function automatic logic [15:0] memword(input logic [15:0] a);
        if (a == halt_at) return 16'hF000;
        return (a ^ 16'h5A5A) & 16'h7FFF;
    endfunction

    function automatic logic exp_req();
        return rst_n && !m_halted && !bus.redirect_valid
               && (!m_valid || !bus.stall);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
        m_halted = 1'b0; m_mis = 1'b0;
    endtask

    // Applies one clock edge of the fetch rules using the inputs of the
    // cycle just ended.
    task automatic model_update();
        logic req, consume, rv, st, rdy;
        logic [15:0] tgt;
        rv = bus.redirect_valid; st = bus.stall; rdy = bus.imem_ready;
        tgt = bus.redirect_target;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_halted) return;
        req     = !rv && (!m_valid || !st);
        consume = m_valid && !st;
        if (consume) m_accepted++;
        if (rv) begin
            m_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (tgt[0]) begin
                m_mis = 1'b1; m_halted = 1'b1;
            end else
                m_pc = tgt;
`else
            m_pc = tgt & 16'hFFFE;
`endif
        end else if (consume && m_instr[15:12] == 4'hF) begin
            m_halted = 1'b1; m_valid = 1'b0;
        end else if (req && rdy) begin
            m_instr = bus.imem_rdata; m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 16'd2;
            $display("fetch addr=%04h data=%04h", m_ipc, m_instr);
        end else if (consume) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic st, input logic rv, input logic [15:0] tgt,
                         input logic rdy);
        bus.stall = st; bus.redirect_valid = rv; bus.redirect_target = tgt;
        bus.imem_ready = rdy; bus.imem_rdata = memword(m_pc);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (bus.imem_req !== 1'b0) begin
            failures++; $display("FAIL reset_req act=%b exp=0", bus.imem_req);
        end
        tick(); tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.misalign_fault !== 1'b0) begin
            failures++; $display("FAIL reset_flags act=%b%b%b exp=000",
                                 bus.instr_valid, bus.halted, bus.misalign_fault);
        end
        checks++;
        if (bus.imem_addr !== RESET_PC || bus.instr !== 16'h0 || bus.instr_pc !== 16'h0) begin
            failures++; $display("FAIL reset_regs addr=%04h instr=%04h ipc=%04h exp=%04h/0000/0000",
                                 bus.imem_addr, bus.instr, bus.instr_pc, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'(2 * k)) begin
                failures++; $display("FAIL seq_addr k=%0d act=%b/%04h exp=1/%04h",
                                     k, bus.imem_req, bus.imem_addr, 16'(2 * k));
            end
            if (k > 0) begin
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(2 * k - 2)
                    || bus.instr !== memword(16'(2 * k - 2)) || bus.pc_plus2 !== 16'(2 * k)) begin
                    failures++; $display("FAIL seq_instr k=%0d act=%b/%04h/%04h/%04h", k,
                                         bus.instr_valid, bus.instr_pc, bus.instr, bus.pc_plus2);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [15:0] s_instr, s_ipc, s_addr;
        s_instr = bus.instr; s_ipc = bus.instr_pc; s_addr = bus.imem_addr;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1);
            checks++;
            if (bus.imem_req !== 1'b0 || bus.imem_addr !== s_addr || bus.instr !== s_instr
                || bus.instr_pc !== s_ipc || bus.instr_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold k=%0d req=%b addr=%04h instr=%04h ipc=%04h exp 0/%04h/%04h/%04h",
                                     k, bus.imem_req, bus.imem_addr, bus.instr, bus.instr_pc,
                                     s_addr, s_instr, s_ipc);
            end
            tick();
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (bus.imem_req !== 1'b1) begin
            failures++; $display("FAIL stall_resume_req act=%b exp=1", bus.imem_req);
        end
        tick();
        checks++;
        if (bus.instr_pc !== s_addr || bus.imem_addr !== s_addr + 16'd2) begin
            failures++; $display("FAIL stall_resume ipc=%04h addr=%04h exp=%04h/%04h",
                                 bus.instr_pc, bus.imem_addr, s_addr, s_addr + 16'd2);
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] s_addr;
        s_addr = bus.imem_addr;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== s_addr) begin
                failures++; $display("FAIL wait_hold k=%0d act=%b/%04h exp=1/%04h",
                                     k, bus.imem_req, bus.imem_addr, s_addr);
            end
            tick();
        end
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL wait_consumed act=%b exp=0", bus.instr_valid);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== s_addr || bus.imem_addr !== s_addr + 16'd2
            || bus.instr !== memword(s_addr)) begin
            failures++; $display("FAIL wait_load v=%b ipc=%04h addr=%04h instr=%04h exp 1/%04h/%04h/%04h",
                                 bus.instr_valid, bus.instr_pc, bus.imem_addr, bus.instr,
                                 s_addr, s_addr + 16'd2, memword(s_addr));
        end
        tick();
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b1, 16'h0040, 1'b1);
        checks++;
        if (bus.imem_req !== 1'b0) begin
            failures++; $display("FAIL redirect_req act=%b exp=0", bus.imem_req);
        end
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0040) begin
            failures++; $display("FAIL redirect_load v=%b addr=%04h exp=0/0040",
                                 bus.instr_valid, bus.imem_addr);
        end
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 16'hFFFE, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (bus.imem_addr !== 16'hFFFE) begin
            failures++; $display("FAIL wrap_addr act=%04h exp=fffe", bus.imem_addr);
        end
        tick();
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (bus.imem_addr !== 16'h0000 || bus.instr_pc !== 16'hFFFE || bus.pc_plus2 !== 16'h0000) begin
            failures++; $display("FAIL wrap_next addr=%04h ipc=%04h p2=%04h exp=0000/fffe/0000",
                                 bus.imem_addr, bus.instr_pc, bus.pc_plus2);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] tgt;
        m_accepted = 0;
        for (int k = 0; k < 300; k++) begin
            tgt = 16'($urandom);
`ifdef PC_ALIGN_CHECK_EN
            tgt[0] = 1'b0;
`endif
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), tgt,
                  ($urandom_range(0, 2) != 0));
            checks++;
            if (bus.imem_req !== exp_req() || bus.imem_addr !== m_pc) begin
                failures++; $display("FAIL rnd_req k=%0d act=%b/%04h exp=%b/%04h",
                                     k, bus.imem_req, bus.imem_addr, exp_req(), m_pc);
            end
            checks++;
            if (bus.instr_valid !== m_valid || bus.instr !== m_instr || bus.instr_pc !== m_ipc
                || bus.pc_plus2 !== m_ipc + 16'd2 || bus.halted !== m_halted
                || bus.misalign_fault !== m_mis) begin
                failures++; $display("FAIL rnd_state k=%0d act=%b/%04h/%04h/%04h/%b exp=%b/%04h/%04h/%04h/%b",
                                     k, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_plus2, bus.halted,
                                     m_valid, m_instr, m_ipc, m_ipc + 16'd2, m_halted);
            end
            tick();
        end
        $display("random run: %0d instructions accepted by decode", m_accepted);
    endtask

    task automatic test_misalign();
        drive(1'b0, 1'b1, 16'h0041, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (bus.misalign_fault !== 1'b1 || bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
            failures++; $display("FAIL misalign act=%b/%b/%b exp=1/1/0",
                                 bus.misalign_fault, bus.halted, bus.imem_req);
        end
`else
        checks++;
        if (bus.misalign_fault !== 1'b0 || bus.imem_addr !== 16'h0040 || bus.halted !== 1'b0) begin
            failures++; $display("FAIL misalign_drop act=%b/%04h/%b exp=0/0040/0",
                                 bus.misalign_fault, bus.imem_addr, bus.halted);
        end
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        halt_at = 16'h0100;
        drive(1'b0, 1'b1, 16'h0100, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hF000 || bus.imem_req !== 1'b1) begin
            failures++; $display("FAIL halt_held v=%b instr=%04h req=%b exp=1/f000/1",
                                 bus.instr_valid, bus.instr, bus.imem_req);
        end
        tick();
        drive(1'b0, 1'b1, 16'h0200, 1'b1);
        checks++;
        if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0
            || bus.imem_addr !== 16'h0102) begin
            failures++; $display("FAIL halt_enter h=%b v=%b req=%b addr=%04h exp=1/0/0/0102",
                                 bus.halted, bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (bus.halted !== 1'b1 || bus.imem_addr !== 16'h0102 || bus.imem_req !== 1'b0) begin
            failures++; $display("FAIL halt_frozen h=%b addr=%04h req=%b exp=1/0102/0",
                                 bus.halted, bus.imem_addr, bus.imem_req);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        checks++;
        if (bus.halted !== 1'b0 || bus.imem_addr !== RESET_PC || bus.imem_req !== 1'b1) begin
            failures++; $display("FAIL halt_restart h=%b addr=%04h req=%b exp=0/%04h/1",
                                 bus.halted, bus.imem_addr, bus.imem_req, RESET_PC);
        end
        tick();
        halt_at = 16'hFFFF;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_wait_states();
        test_redirect();
        test_wrap();
        test_random();
        test_misalign();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
